mem_port_arbiter: RTL and testbench

//  Shares the single unified RAM port of the multi-cycle MIPS core between the CPU (fetch/load/store) and a DMA/loader.
//  Two-way round-robin arbitration, fixed-latency RAM sequencing, alignment checking; REQ/ACK handshake per requester.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arb_rr_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified RAM port arbiter: FSM states,
// access-size codes, requester identifiers and the alignment rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  // An access is rejected when the size is reserved or the address is not
  // naturally aligned to the access size.
  function automatic logic align_err(input logic [1:0] sel, input logic [1:0] addr_lo);
    logic err;
    case (sel)
      SEL_BYTE: err = 1'b0;
      SEL_HALF: err = addr_lo[0];
      SEL_WORD: err = (addr_lo != 2'b00);
      default:  err = 1'b1;
    endcase
    return err;
  endfunction

  // GRANT bit layout is {DMA, CPU}.
  function automatic logic [1:0] grant_onehot(input req_id_t id);
    return (id == REQ_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker. Holds the identity of the last granted
// requester and, on a tie, favours the other one. Reset leaves DMA as the
// last winner so the CPU takes the first tie.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic take,
  output logic valid,
  output logic pick_dma
);

  req_id_t last_grant_reg;

  // Choose a winner from the current requests and the last owner.
  always_comb begin
    valid    = cpu_req | dma_req;
    pick_dma = 1'b0;
    if (cpu_req && dma_req) begin
      pick_dma = (last_grant_reg == REQ_CPU);
    end else begin
      pick_dma = dma_req;
    end
  end

  // Remember who won, only when the arbiter actually consumes the pick.
  always_ff @(posedge clk) begin
    if (srst) begin
      last_grant_reg <= REQ_DMA;
    end else if (take && valid) begin
      last_grant_reg <= pick_dma ? REQ_DMA : REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the CPU and a DMA/loader. Each granted access
// runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE, or IDLE -> DONE when the
// request is misaligned. RAM-side signals come only from the request copy
// latched at grant time, so requesters may change their buses afterwards.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int MEM_LAT          = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CPU_REQ,
  input  logic                        CPU_WE,
  input  logic [1:0]                  CPU_SEL,
  input  logic [ADDRESS_WIDTH-1:0]    CPU_ADDR,
  input  logic [INSTR_DATA_WIDTH-1:0] CPU_WDATA,
  output logic                        CPU_ACK,
  output logic                        CPU_ERR,
  output logic [INSTR_DATA_WIDTH-1:0] CPU_RDATA,
  input  logic                        DMA_REQ,
  input  logic                        DMA_WE,
  input  logic [1:0]                  DMA_SEL,
  input  logic [ADDRESS_WIDTH-1:0]    DMA_ADDR,
  input  logic [INSTR_DATA_WIDTH-1:0] DMA_WDATA,
  output logic                        DMA_ACK,
  output logic                        DMA_ERR,
  output logic [INSTR_DATA_WIDTH-1:0] DMA_RDATA,
  output logic                        RAM_EN,
  output logic                        RAM_WS,
  output logic [1:0]                  RAM_SEL,
  output logic [ADDRESS_WIDTH-1:0]    RAM_ADDR,
  output logic [INSTR_DATA_WIDTH-1:0] RAM_WDATA,
  input  logic [INSTR_DATA_WIDTH-1:0] RAM_RDATA,
  output logic [1:0]                  GRANT
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  arb_state_t                  state_reg;
  logic [CW-1:0]               cnt_reg;
  req_id_t                     owner_reg;
  logic                        we_reg;
  logic [1:0]                  sel_reg;
  logic [ADDRESS_WIDTH-1:0]    addr_reg;
  logic [INSTR_DATA_WIDTH-1:0] wdata_reg;
  logic                        ram_en_reg;
  logic                        ram_ws_reg;
  logic                        cpu_ack_reg;
  logic                        dma_ack_reg;
  logic                        cpu_err_reg;
  logic                        dma_err_reg;
  logic [INSTR_DATA_WIDTH-1:0] cpu_rdata_reg;
  logic [INSTR_DATA_WIDTH-1:0] dma_rdata_reg;
  logic [1:0]                  grant_reg;

  logic                        pick_valid;
  logic                        pick_dma;
  logic                        take;
  req_id_t                     pick_id;
  logic                        req_we;
  logic [1:0]                  req_sel;
  logic [ADDRESS_WIDTH-1:0]    req_addr;
  logic [INSTR_DATA_WIDTH-1:0] req_wdata;

  // The picker is only consulted while idle; elsewhere REQ changes are ignored.
  assign take = (state_reg == ST_IDLE);

  mem_arb_rr_pick u_pick (
    .clk      (CLK),
    .srst     (RST),
    .cpu_req  (CPU_REQ),
    .dma_req  (DMA_REQ),
    .take     (take),
    .valid    (pick_valid),
    .pick_dma (pick_dma)
  );

  // Route the winning requester's access fields toward the latch registers.
  always_comb begin
    pick_id   = pick_dma ? REQ_DMA : REQ_CPU;
    req_we    = pick_dma ? DMA_WE    : CPU_WE;
    req_sel   = pick_dma ? DMA_SEL   : CPU_SEL;
    req_addr  = pick_dma ? DMA_ADDR  : CPU_ADDR;
    req_wdata = pick_dma ? DMA_WDATA : CPU_WDATA;
  end

  // Sequencing FSM; every output is a register updated alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      owner_reg     <= REQ_CPU;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      ram_en_reg    <= 1'b0;
      ram_ws_reg    <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      cpu_err_reg   <= 1'b0;
      dma_err_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
      dma_rdata_reg <= '0;
      grant_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_reg <= pick_id;
            we_reg    <= req_we;
            sel_reg   <= req_sel;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            grant_reg <= grant_onehot(pick_id);
            if (align_err(req_sel, req_addr[1:0])) begin
              // Rejected access: complete immediately, the RAM is never touched.
              state_reg <= ST_DONE;
              if (pick_id == REQ_DMA) begin
                dma_ack_reg <= 1'b1;
                dma_err_reg <= 1'b1;
              end else begin
                cpu_ack_reg <= 1'b1;
                cpu_err_reg <= 1'b1;
              end
            end else begin
              state_reg  <= ST_ACCESS;
              cnt_reg    <= LAT_INIT;
              ram_en_reg <= 1'b1;
              ram_ws_reg <= req_we;
            end
          end
        end

        ST_ACCESS: begin
          if (cnt_reg == CNT_LAST) begin
            // Last RAM cycle: read data is valid now and is captured on this edge.
            state_reg  <= ST_DONE;
            ram_en_reg <= 1'b0;
            ram_ws_reg <= 1'b0;
            if (owner_reg == REQ_DMA) begin
              dma_ack_reg <= 1'b1;
              if (!we_reg) dma_rdata_reg <= RAM_RDATA;
            end else begin
              cpu_ack_reg <= 1'b1;
              if (!we_reg) cpu_rdata_reg <= RAM_RDATA;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_LAST;
          end
        end

        ST_DONE: begin
          state_reg   <= ST_IDLE;
          cpu_ack_reg <= 1'b0;
          dma_ack_reg <= 1'b0;
          cpu_err_reg <= 1'b0;
          dma_err_reg <= 1'b0;
          grant_reg   <= '0;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign CPU_ACK   = cpu_ack_reg;
  assign CPU_ERR   = cpu_err_reg;
  assign CPU_RDATA = cpu_rdata_reg;
  assign DMA_ACK   = dma_ack_reg;
  assign DMA_ERR   = dma_err_reg;
  assign DMA_RDATA = dma_rdata_reg;
  assign RAM_EN    = ram_en_reg;
  assign RAM_WS    = ram_ws_reg;
  assign RAM_SEL   = sel_reg;
  assign RAM_ADDR  = addr_reg;
  assign RAM_WDATA = wdata_reg;
  assign GRANT     = grant_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances: the main one with
// MEM_LAT=2 and two extra ones (MEM_LAT=1 and 5) exercising latency scaling.
// Cycle 0 of each scenario is the cycle in which REQ is first presented;
// outputs are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [1:0]  cpu_sel;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        dma_req, dma_we;
  logic [1:0]  dma_sel;
  logic [31:0] dma_addr, dma_wdata;
  logic [31:0] ram_rdata;

  logic        cpu_ack, cpu_err, dma_ack, dma_err, ram_en, ram_ws;
  logic [31:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata;
  logic [1:0]  ram_sel, grant;

  logic        cpu_req1, cpu_req5;
  logic        z_req, z_we;
  logic [1:0]  z_sel;
  logic [31:0] z_bus;

  logic        a1_cack, a1_cerr, a1_dack, a1_derr, a1_en, a1_ws;
  logic [31:0] a1_crd, a1_drd, a1_addr, a1_wd;
  logic [1:0]  a1_sel, a1_grant;
  logic        a5_cack, a5_cerr, a5_dack, a5_derr, a5_en, a5_ws;
  logic [31:0] a5_crd, a5_drd, a5_addr, a5_wd;
  logic [1:0]  a5_sel, a5_grant;

  int total;
  int bad;

  mem_port_arbiter #(.ADDRESS_WIDTH(32), .INSTR_DATA_WIDTH(32), .MEM_LAT(2)) dut (
    .CLK(clk), .RST(rst),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_SEL(cpu_sel), .CPU_ADDR(cpu_addr),
    .CPU_WDATA(cpu_wdata), .CPU_ACK(cpu_ack), .CPU_ERR(cpu_err), .CPU_RDATA(cpu_rdata),
    .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_SEL(dma_sel), .DMA_ADDR(dma_addr),
    .DMA_WDATA(dma_wdata), .DMA_ACK(dma_ack), .DMA_ERR(dma_err), .DMA_RDATA(dma_rdata),
    .RAM_EN(ram_en), .RAM_WS(ram_ws), .RAM_SEL(ram_sel), .RAM_ADDR(ram_addr),
    .RAM_WDATA(ram_wdata), .RAM_RDATA(ram_rdata), .GRANT(grant)
  );

  mem_port_arbiter #(.ADDRESS_WIDTH(32), .INSTR_DATA_WIDTH(32), .MEM_LAT(1)) dut_l1 (
    .CLK(clk), .RST(rst),
    .CPU_REQ(cpu_req1), .CPU_WE(cpu_we), .CPU_SEL(cpu_sel), .CPU_ADDR(cpu_addr),
    .CPU_WDATA(cpu_wdata), .CPU_ACK(a1_cack), .CPU_ERR(a1_cerr), .CPU_RDATA(a1_crd),
    .DMA_REQ(z_req), .DMA_WE(z_we), .DMA_SEL(z_sel), .DMA_ADDR(z_bus),
    .DMA_WDATA(z_bus), .DMA_ACK(a1_dack), .DMA_ERR(a1_derr), .DMA_RDATA(a1_drd),
    .RAM_EN(a1_en), .RAM_WS(a1_ws), .RAM_SEL(a1_sel), .RAM_ADDR(a1_addr),
    .RAM_WDATA(a1_wd), .RAM_RDATA(ram_rdata), .GRANT(a1_grant)
  );

  mem_port_arbiter #(.ADDRESS_WIDTH(32), .INSTR_DATA_WIDTH(32), .MEM_LAT(5)) dut_l5 (
    .CLK(clk), .RST(rst),
    .CPU_REQ(cpu_req5), .CPU_WE(cpu_we), .CPU_SEL(cpu_sel), .CPU_ADDR(cpu_addr),
    .CPU_WDATA(cpu_wdata), .CPU_ACK(a5_cack), .CPU_ERR(a5_cerr), .CPU_RDATA(a5_crd),
    .DMA_REQ(z_req), .DMA_WE(z_we), .DMA_SEL(z_sel), .DMA_ADDR(z_bus),
    .DMA_WDATA(z_bus), .DMA_ACK(a5_dack), .DMA_ERR(a5_derr), .DMA_RDATA(a5_drd),
    .RAM_EN(a5_en), .RAM_WS(a5_ws), .RAM_SEL(a5_sel), .RAM_ADDR(a5_addr),
    .RAM_WDATA(a5_wd), .RAM_RDATA(ram_rdata), .GRANT(a5_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the invariants of the main instance.
  task automatic step();
    @(posedge clk);
    #1;
    chk1("no_double_ack", cpu_ack & dma_ack, 1'b0);
    chk1("grant_not_11", grant == 2'b11, 1'b0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_sel = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_sel = 2'b00; dma_addr = '0; dma_wdata = '0;
    cpu_req1 = 1'b0; cpu_req5 = 1'b0;
    z_req = 1'b0; z_we = 1'b0; z_sel = 2'b00; z_bus = '0;
    ram_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk1("rst_ram_en", ram_en, 1'b0);
    chk1("rst_ram_ws", ram_ws, 1'b0);
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_dma_ack", dma_ack, 1'b0);
    chk32("rst_grant", {30'b0, grant}, 32'h0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk32("rst_dma_rdata", dma_rdata, 32'h0);
    chk32("rst_ram_addr", ram_addr, 32'h0);

    // 1: CPU word read at 0x100
    cpu_we = 1'b0; cpu_sel = 2'b10; cpu_addr = 32'h100; cpu_req = 1'b1;
    ram_rdata = 32'hDEADBEEF;
    step();
    chk1("t1_en_c1", ram_en, 1'b1);
    chk1("t1_ws_c1", ram_ws, 1'b0);
    chk32("t1_addr_c1", ram_addr, 32'h100);
    chk32("t1_grant_c1", {30'b0, grant}, 32'h1);
    chk1("t1_ack_c1", cpu_ack, 1'b0);
    step();
    chk1("t1_en_c2", ram_en, 1'b1);
    chk1("t1_ack_c2", cpu_ack, 1'b0);
    step();
    chk1("t1_en_c3", ram_en, 1'b0);
    chk1("t1_ack_c3", cpu_ack, 1'b1);
    chk1("t1_err_c3", cpu_err, 1'b0);
    chk32("t1_rdata_c3", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    step();
    chk1("t1_ack_c4", cpu_ack, 1'b0);
    chk32("t1_grant_c4", {30'b0, grant}, 32'h0);

    // 2: contention after a fresh reset; CPU wins first, then DMA, then CPU
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_we = 1'b0; cpu_sel = 2'b10; cpu_addr = 32'h104; cpu_req = 1'b1;
    dma_we = 1'b1; dma_sel = 2'b10; dma_addr = 32'h200; dma_wdata = 32'h55; dma_req = 1'b1;
    ram_rdata = 32'h11112222;
    step();
    chk32("t2_grant_c1", {30'b0, grant}, 32'h1);
    chk32("t2_addr_c1", ram_addr, 32'h104);
    chk1("t2_ws_c1", ram_ws, 1'b0);
    step();
    step();
    chk1("t2_cack_c3", cpu_ack, 1'b1);
    chk1("t2_dack_c3", dma_ack, 1'b0);
    chk32("t2_crd_c3", cpu_rdata, 32'h11112222);
    cpu_addr = 32'h108;
    ram_rdata = 32'h33334444;
    step();
    chk32("t2_grant_c4", {30'b0, grant}, 32'h0);
    step();
    chk32("t2_grant_c5", {30'b0, grant}, 32'h2);
    chk1("t2_en_c5", ram_en, 1'b1);
    chk1("t2_ws_c5", ram_ws, 1'b1);
    chk32("t2_addr_c5", ram_addr, 32'h200);
    chk32("t2_wdata_c5", ram_wdata, 32'h55);
    chk32("t2_sel_c5", {30'b0, ram_sel}, 32'h2);
    dma_addr = 32'h999;
    dma_wdata = 32'hFFFF;
    step();
    chk32("t2_addr_held_c6", ram_addr, 32'h200);
    chk32("t2_wdata_held_c6", ram_wdata, 32'h55);
    step();
    chk1("t2_dack_c7", dma_ack, 1'b1);
    chk1("t2_derr_c7", dma_err, 1'b0);
    chk1("t2_cack_c7", cpu_ack, 1'b0);
    chk32("t2_drd_c7", dma_rdata, 32'h0);
    chk32("t2_crd_kept_c7", cpu_rdata, 32'h11112222);
    dma_req = 1'b0;
    step();
    chk32("t2_grant_c8", {30'b0, grant}, 32'h0);
    step();
    chk32("t2_grant_c9", {30'b0, grant}, 32'h1);
    chk32("t2_addr_c9", ram_addr, 32'h108);
    step();
    step();
    chk1("t2_cack_c11", cpu_ack, 1'b1);
    chk32("t2_crd_c11", cpu_rdata, 32'h33334444);
    cpu_req = 1'b0;
    step();

    // 3: misaligned half and reserved size from DMA, misaligned word from CPU
    dma_we = 1'b1; dma_sel = 2'b01; dma_addr = 32'h301; dma_wdata = 32'h77; dma_req = 1'b1;
    step();
    chk1("t3_dack_c1", dma_ack, 1'b1);
    chk1("t3_derr_c1", dma_err, 1'b1);
    chk1("t3_en_c1", ram_en, 1'b0);
    chk32("t3_grant_c1", {30'b0, grant}, 32'h2);
    chk32("t3_drd_c1", dma_rdata, 32'h0);
    dma_req = 1'b0;
    step();
    chk1("t3_dack_c2", dma_ack, 1'b0);
    chk1("t3_en_c2", ram_en, 1'b0);
    dma_sel = 2'b11; dma_addr = 32'h300; dma_req = 1'b1;
    step();
    chk1("t3_rsvd_dack", dma_ack, 1'b1);
    chk1("t3_rsvd_derr", dma_err, 1'b1);
    chk1("t3_rsvd_en", ram_en, 1'b0);
    dma_req = 1'b0;
    step();
    chk1("t3_rsvd_en_after", ram_en, 1'b0);
    cpu_we = 1'b0; cpu_sel = 2'b10; cpu_addr = 32'h102; cpu_req = 1'b1;
    step();
    chk1("t3_word_cack", cpu_ack, 1'b1);
    chk1("t3_word_cerr", cpu_err, 1'b1);
    chk1("t3_word_en", ram_en, 1'b0);
    chk32("t3_word_crd", cpu_rdata, 32'h33334444);
    cpu_req = 1'b0;
    step();

    // 4: reset during the second ACCESS cycle of a CPU read
    cpu_we = 1'b0; cpu_sel = 2'b10; cpu_addr = 32'h100; cpu_req = 1'b1;
    ram_rdata = 32'h12345678;
    step();
    chk1("t4_en_c1", ram_en, 1'b1);
    step();
    chk1("t4_en_c2", ram_en, 1'b1);
    rst = 1'b1;
    step();
    chk1("t4_en_c3", ram_en, 1'b0);
    chk1("t4_ws_c3", ram_ws, 1'b0);
    chk1("t4_ack_c3", cpu_ack, 1'b0);
    chk32("t4_grant_c3", {30'b0, grant}, 32'h0);
    chk32("t4_crd_c3", cpu_rdata, 32'h0);
    rst = 1'b0;
    ram_rdata = 32'hCAFEF00D;
    step();
    chk1("t4_en_c4", ram_en, 1'b1);
    chk32("t4_grant_c4", {30'b0, grant}, 32'h1);
    step();
    step();
    chk1("t4_ack_c6", cpu_ack, 1'b1);
    chk1("t4_err_c6", cpu_err, 1'b0);
    chk32("t4_crd_c6", cpu_rdata, 32'hCAFEF00D);
    cpu_req = 1'b0;
    step();

    // 5: byte write 0x7 <- 0xA5 with MEM_LAT=1 and MEM_LAT=5
    cpu_we = 1'b1; cpu_sel = 2'b00; cpu_addr = 32'h7; cpu_wdata = 32'hA5;
    cpu_req1 = 1'b1; cpu_req5 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk1($sformatf("t5_l1_ws_c%0d", c), a1_ws, (c == 1));
      chk1($sformatf("t5_l1_ack_c%0d", c), a1_cack, (c == 2));
      chk1($sformatf("t5_l5_ws_c%0d", c), a5_ws, (c <= 5));
      chk1($sformatf("t5_l5_ack_c%0d", c), a5_cack, (c == 6));
      if (c == 1) begin
        chk32("t5_l1_wdata", a1_wd, 32'hA5);
        chk32("t5_l5_addr", a5_addr, 32'h7);
        chk32("t5_l5_sel", {30'b0, a5_sel}, 32'h0);
      end
      if (c == 2) cpu_req1 = 1'b0;
      if (c == 6) cpu_req5 = 1'b0;
    end
    step();
    chk1("t5_l5_ack_after", a5_cack, 1'b0);
    chk1("t5_l1_err", a1_cerr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
